// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory, stalls on mem_ready, counts retired instructions.
module multicycle_control_fsm #(
  parameter int SUPPORT_IMM_ALU = 1,
  parameter int SUPPORT_JAL     = 1,
  parameter int MEM_HANDSHAKE   = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_rdy;
  logic             w_retire;
  logic             w_pc_update;
  logic             w_branch;

  // Without the handshake every memory access completes in one cycle.
  assign w_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign instret = r_instret;

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Next-state and Moore control decode; everything is forced low in reset.
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    imm_src     = 2'b00;
    illegal     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = w_rdy;
        w_pc_update = w_rdy;
        if (w_rdy)
          w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        w_next    = S_FETCH;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_BEQ:       w_next = S_BEQ;
          OP_I: begin
            if (SUPPORT_IMM_ALU != 0)
              w_next = S_EXECI;
            else
              illegal = 1'b1;
          end
          OP_JAL: begin
            if (SUPPORT_JAL != 0)
              w_next = S_JAL;
            else
              illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (w_rdy)
          w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (w_rdy) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
    pc_write = w_pc_update | (w_branch & zero);
    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 2'b00;
      illegal    = 1'b0;
    end
  end

endmodule
